// File: rtl/bcd_seg_display.sv
// bcd_seg_display: valid/ready binary-to-7-segment driver (double-dabble decimal or hex), registered output.
module bcd_seg_display #(
  parameter int WIDTH = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  out_valid
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;
  // 10^DIGITS > 2^WIDTH-1  <=>  DIGITS > WIDTH*log10(2); equality never occurs for WIDTH >= 1
  if (WIDTH < 1 || real'(DIGITS) <= real'(WIDTH) * 0.30102999566) begin : g_bad
    $error("bcd_seg_display: DIGITS too small for WIDTH");
  end
  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'b1000000;
      4'h1: enc = 7'b1111001;
      4'h2: enc = 7'b0100100;
      4'h3: enc = 7'b0110000;
      4'h4: enc = 7'b0011001;
      4'h5: enc = 7'b0010010;
      4'h6: enc = 7'b0000010;
      4'h7: enc = 7'b1111000;
      4'h8: enc = 7'b0000000;
      4'h9: enc = 7'b0011000;
      4'hA: enc = 7'b0001000;
      4'hB: enc = 7'b0000011;
      4'hC: enc = 7'b1000110;
      4'hD: enc = 7'b0100001;
      4'hE: enc = 7'b0000110;
      default: enc = 7'b0001110;
    endcase
  endfunction
  logic [0:0]          state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [BW-1:0]       bcd_q, bcd_d, dec_bcd, hexv, nxt_bcd;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                hex_q, hex_d, blz_q, blz_d, ov_q, ov_d;
  logic [7*DIGITS-1:0] seg_q, seg_d, enc_seg;
  for (genvar j = 0; j < BW; j++) begin : g_hex
    if (j < WIDTH) begin : g_b
      assign hexv[j] = shift_q[j];
    end else begin : g_z
      assign hexv[j] = 1'b0;
    end
  end
  // add-3 then shift: each nibble takes the carry-out of the one below, nibble 0 takes the value MSB
  always_comb begin
    logic [3:0] a;
    logic       c;
    c = shift_q[WIDTH-1];
    dec_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      a = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
      dec_bcd[4*i+:4] = {a[2:0], c};
      c = a[3];
    end
    nxt_bcd = hex_q ? hexv : dec_bcd;
  end
  always_comb begin
    logic lead;
    lead = blz_q;
    enc_seg = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = lead && nxt_bcd[4*i+:4] == 4'd0 && i != 0;
      enc_seg[7*i+:7] = lead ? 7'h7f : enc(nxt_bcd[4*i+:4]);
    end
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    blz_d   = blz_q;
    seg_d   = seg_q;
    ov_d    = 1'b0;
    if (state_q == IDLE && in_valid) begin
      shift_d = in_data;
      bcd_d   = '0;
      cnt_d   = hex_mode ? CW'(1) : CW'(WIDTH);
      hex_d   = hex_mode;
      blz_d   = blank_lz;
      state_d = CONV;
    end else if (state_q == CONV) begin
      bcd_d   = nxt_bcd;
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        seg_d   = enc_seg;
        ov_d    = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
      blz_q   <= 1'b0;
      seg_q   <= '1;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      blz_q   <= blz_d;
      seg_q   <= seg_d;
      ov_q    <= ov_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign seg       = seg_q;
  assign out_valid = ov_q;
endmodule
